// File: rtl/ctd_pkg.sv
// Shared BCD types, constants and helpers for the mm:ss countdown engine.
package ctd_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t BCD_ZERO = 8'h00;
    localparam bcd2_t BCD_59   = 8'h59;
    localparam bcd2_t BCD_MAX  = 8'h99;
    localparam bcd2_t WARN_SEC = 8'h10;

    function automatic logic bcd_valid(input bcd2_t value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/ctd_mmss_core_if.sv
// Control/status bundle between the timer state machine (master) and the countdown core (slave).
// The warn flag only exists when CTD_WARN_EN is defined.
interface ctd_mmss_core_if;
    import ctd_pkg::*;

    logic  cnt_en;
    logic  load;
    bcd2_t min_init;
    bcd2_t xmin;
    bcd2_t xsec;
    logic  time_out;
    logic  sec_tick;
    logic  running;
`ifdef CTD_WARN_EN
    logic  warn;

    modport master (output cnt_en, load, min_init,
                    input  xmin, xsec, time_out, sec_tick, running, warn);
    modport slave  (input  cnt_en, load, min_init,
                    output xmin, xsec, time_out, sec_tick, running, warn);
`else
    modport master (output cnt_en, load, min_init,
                    input  xmin, xsec, time_out, sec_tick, running);
    modport slave  (input  cnt_en, load, min_init,
                    output xmin, xsec, time_out, sec_tick, running);
`endif

endinterface

// File: rtl/ctd_mmss_core_bcd2_dec.sv
// Combinational two-digit BCD decrement; 00 wraps to the supplied value and raises borrow.
module bcd2_dec
    import ctd_pkg::*;
(
    input  bcd2_t value,
    input  bcd2_t wrap,
    output bcd2_t result,
    output logic  borrow
);

    always_comb begin
        result = value;
        borrow = 1'b0;
        if (value == BCD_ZERO) begin
            result = wrap;
            borrow = 1'b1;
        end else if (value[3:0] == 4'd0) begin
            result = {value[7:4] - 4'd1, 4'd9};
        end else begin
            result = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/ctd_mmss_core.sv
// Countdown engine: BCD mm:ss decremented once per TICK_DIV clocks while enabled.
// Optional 0.5 s flashing warn output is built when CTD_WARN_EN is defined.
module ctd_mmss_core
    import ctd_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int PS_W     = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    ctd_mmss_core_if.slave   bus
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] prescaler;
    bcd2_t           xmin_q;
    bcd2_t           xsec_q;
    logic            time_out_q;
    logic            sec_tick_q;
    logic            running_q;

    bcd2_t           sec_dec;
    bcd2_t           min_dec;
    logic            sec_borrow;
    logic            min_borrow;
    logic            counting;
    logic            wrap;

    bcd2_dec u_sec_dec (
        .value  (xsec_q),
        .wrap   (BCD_59),
        .result (sec_dec),
        .borrow (sec_borrow)
    );

    bcd2_dec u_min_dec (
        .value  (xmin_q),
        .wrap   (BCD_ZERO),
        .result (min_dec),
        .borrow (min_borrow)
    );

    assign counting = bus.cnt_en && !time_out_q;
    assign wrap     = counting && (prescaler == PS_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            xmin_q     <= BCD_ZERO;
            xsec_q     <= BCD_ZERO;
            time_out_q <= 1'b0;
            sec_tick_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            running_q  <= bus.cnt_en & ~time_out_q;
            sec_tick_q <= 1'b0;
            if (bus.load) begin
                xmin_q     <= bcd_valid(bus.min_init) ? bus.min_init : BCD_MAX;
                xsec_q     <= BCD_ZERO;
                prescaler  <= '0;
                time_out_q <= 1'b0;
            end else if (counting) begin
                if (wrap) begin
                    prescaler <= '0;
                    // Borrow flags double as "digit pair is 00" tests.
                    if (!sec_borrow) begin
                        xsec_q     <= sec_dec;
                        sec_tick_q <= 1'b1;
                        if (min_borrow && (sec_dec == BCD_ZERO))
                            time_out_q <= 1'b1;
                    end else if (!min_borrow) begin
                        xsec_q     <= BCD_59;
                        xmin_q     <= min_dec;
                        sec_tick_q <= 1'b1;
                    end else begin
                        time_out_q <= 1'b1;
                    end
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

    assign bus.xmin     = xmin_q;
    assign bus.xsec     = xsec_q;
    assign bus.time_out = time_out_q;
    assign bus.sec_tick = sec_tick_q;
    assign bus.running  = running_q;

`ifdef CTD_WARN_EN
    localparam logic [PS_W-1:0] PS_PRE_HALF = PS_W'(TICK_DIV / 2 - 1);

    logic warn_q;
    logic warn_zone;
    logic half_step;

    assign warn_zone = min_borrow && (xsec_q <= WARN_SEC) && !time_out_q;
    assign half_step = wrap || (counting && (prescaler == PS_PRE_HALF));

    // Flashes at half-second steps only inside the last ten seconds.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.load) begin
            warn_q <= 1'b0;
        end else if (!warn_zone) begin
            warn_q <= 1'b0;
        end else if (half_step) begin
            warn_q <= ~warn_q;
        end
    end

    assign bus.warn = warn_q;
`endif

endmodule

// File: tb/tb_ctd_mmss_core.sv
// Scoreboard bench for ctd_mmss_core with TICK_DIV=4, checked against a seconds-remaining model.
module tb_ctd_mmss_core;

    localparam int TICK_DIV = 4;

    typedef struct {
        logic [7:0] xmin;
        logic [7:0] xsec;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int   checks = 0;
    int   errors = 0;

    int   rem   = 0;
    int   phase = 0;
    bit   m_to   = 1'b0;
    bit   m_tick = 1'b0;
    bit   m_run  = 1'b0;
    exp_t sb[$];
    logic mon_prev_to = 1'b0;

    ctd_mmss_core_if bus ();

    ctd_mmss_core #(.TICK_DIV(TICK_DIV), .PS_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic int load_secs(input logic [7:0] mi);
        if (mi[7:4] > 4'd9 || mi[3:0] > 4'd9)
            return 99 * 60;
        return (int'(mi[7:4]) * 10 + int'(mi[3:0])) * 60;
    endfunction

    // Reference model: one clock edge, state held as total seconds left.
    task automatic model_step(input logic r, input logic ce, input logic ld, input logic [7:0] mi);
        bit old_to;
        exp_t e;
        old_to = m_to;
        m_tick = 1'b0;
        if (!r) begin
            rem = 0; phase = 0; m_to = 1'b0; m_run = 1'b0;
        end else begin
            m_run = ce && !old_to;
            if (ld) begin
                rem = load_secs(mi); phase = 0; m_to = 1'b0;
            end else if (ce && !old_to) begin
                phase++;
                if (phase == TICK_DIV) begin
                    phase = 0;
                    if (rem > 0) begin
                        rem--;
                        m_tick = 1'b1;
                        if (rem == 0) m_to = 1'b1;
                    end else begin
                        m_to = 1'b1;
                    end
                end
            end
            if (m_tick || (m_to && !old_to)) begin
                e.xmin = to_bcd(rem / 60);
                e.xsec = to_bcd(rem % 60);
                e.to   = m_to;
                sb.push_back(e);
            end
        end
    endtask

    task automatic apply_stimulus(input logic r, input logic ce, input logic ld, input logic [7:0] mi);
        @(negedge clk);
        rst_n        = r;
        bus.cnt_en   = ce;
        bus.load     = ld;
        bus.min_init = mi;
        @(posedge clk);
        model_step(r, ce, ld, mi);
    endtask

    task automatic check_output(input string name);
        logic [7:0] emin, esec;
        #1;
        emin = to_bcd(rem / 60);
        esec = to_bcd(rem % 60);
        checks++;
        if (bus.xmin !== emin || bus.xsec !== esec || bus.time_out !== m_to ||
            bus.sec_tick !== m_tick || bus.running !== m_run) begin
            errors++;
            $display("[TB] FAIL %s: got %h:%h to=%b tick=%b run=%b, expected %h:%h to=%b tick=%b run=%b",
                     name, bus.xmin, bus.xsec, bus.time_out, bus.sec_tick, bus.running,
                     emin, esec, m_to, m_tick, m_run);
        end
    endtask

    // Monitor: every decrement or time_out rise must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sec_tick === 1'b1 || (bus.time_out === 1'b1 && mon_prev_to !== 1'b1)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL event: got unexpected %h:%h to=%b, expected no event",
                         bus.xmin, bus.xsec, bus.time_out);
            end else begin
                e = sb.pop_front();
                if (bus.xmin !== e.xmin || bus.xsec !== e.xsec || bus.time_out !== e.to) begin
                    errors++;
                    $display("[TB] FAIL event: got %h:%h to=%b, expected %h:%h to=%b",
                             bus.xmin, bus.xsec, bus.time_out, e.xmin, e.xsec, e.to);
                end
            end
        end
        mon_prev_to = bus.time_out;
    end

    initial begin
        logic [7:0] mi;
        logic r, ce, ld;
        int guard;
        bus.cnt_en   = 1'b0;
        bus.load     = 1'b0;
        bus.min_init = 8'h00;

        repeat (3) apply_stimulus(1'b0, 1'b1, 1'b1, 8'h02);
        check_output("reset");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h02);
        check_output("load_after_reset");

        repeat (4) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
        check_output("first_tick");
        repeat (119 * 4 + 6) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
        check_output("expired");

        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h10);
        repeat (6) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (20) apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
        check_output("paused");
        repeat (2) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
        check_output("resume");

        apply_stimulus(1'b1, 1'b0, 1'b1, 8'h3A);
        check_output("sanitise_3A");
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'hA5);
        check_output("sanitise_A5");

        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h05);
        repeat (12) apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
        guard = 0;
        while (phase != TICK_DIV - 1 && guard < 10) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00);
            guard++;
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h07);
        check_output("load_on_wrap");

        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 199) != 0);
            ld = ($urandom_range(0, 39) == 0);
            ce = ($urandom_range(0, 9) != 0);
            mi = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'd0, 4'($urandom_range(0, 1))};
            apply_stimulus(r, ce, ld, mi);
            if (i % 25 == 24) check_output("random");
        end

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d unmatched expected events, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
